// File: rtl/neuro_spike_scheduler_pkg.sv
// Shared types and default widths for the neuro-nav spike scheduler slice.
package neuro_nav_pkg;

    localparam int MAG_W  = 16;
    localparam int W_W    = 8;
    localparam int REFR_W = 8;

    typedef enum logic [1:0] {
        DIR_PX = 2'd0,
        DIR_PY = 2'd1,
        DIR_NX = 2'd2,
        DIR_NY = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_PENDING = 2'd1,
        CH_REFRACT = 2'd2
    } ch_state_t;

endpackage

// File: rtl/neuro_spike_scheduler_if.sv
// Host move request and update stream bundle; master is the scheduler side.
interface neuro_spike_scheduler_if #(
    parameter int MAG_W = neuro_nav_pkg::MAG_W
);
    logic             host_valid;
    logic [1:0]       host_dir;
    logic [MAG_W-1:0] host_mag;
    logic             host_ready;
    logic             upd_valid;
    logic [1:0]       upd_dir;
    logic [MAG_W-1:0] upd_mag;
    logic             upd_src;
    logic             upd_ready;

    modport master (
        input  host_valid, host_dir, host_mag, upd_ready,
        output host_ready, upd_valid, upd_dir, upd_mag, upd_src
    );

    modport slave (
        output host_valid, host_dir, host_mag, upd_ready,
        input  host_ready, upd_valid, upd_dir, upd_mag, upd_src
    );
endinterface

// File: rtl/neuro_spike_scheduler_rr_arb4.sv
// Four-request round-robin arbiter; search starts at the pointer and the
// pointer moves past the winner only when the caller actually takes the grant.
module spike_rr_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       advance,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       any_req
);
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic       found;

    // Pick the first requester at or above the pointer, wrapping mod 4.
    always_comb begin
        idx       = ptr_q;
        found     = 1'b0;
        grant_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        any_req = found;
        grant   = found ? (4'b0001 << grant_idx) : 4'b0000;
        ptr_d   = (advance && found) ? grant_idx + 2'd1 : ptr_q;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/neuro_spike_scheduler.sv
// Spike/host update scheduler for the neuro-nav SLAM datapath.
// Optional refractory period per channel: define NEURO_SCHED_REFRACTORY_EN.
module neuro_spike_scheduler
    import neuro_nav_pkg::*;
#(
    parameter int MAG_W  = 16,
    parameter int W_W    = 8,
    parameter int REFR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [3:0]          spike_in,
    input  logic [4*W_W-1:0]    weight_in,
    input  logic [REFR_W-1:0]   refr_cycles,
    neuro_spike_scheduler_if.master bus,
    output logic [7:0]          drop_cnt,
    output logic                busy
);
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       rise, rise_en, pend, drop_vec, grant;
    logic [1:0]       grant_idx;
    logic             any_req, load, host_take, spike_take;
    logic [2:0]       n_drop;
    logic [8:0]       drop_sum;
    logic [W_W-1:0]   sel_w;
    ch_state_t        state_q [4];
    ch_state_t        state_d [4];
    logic             upd_valid_q, upd_valid_d, upd_src_q, upd_src_d;
    dir_t             upd_dir_q, upd_dir_d;
    logic [MAG_W-1:0] upd_mag_q, upd_mag_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
`ifdef NEURO_SCHED_REFRACTORY_EN
    logic [REFR_W-1:0] refr_q [4];
    logic [REFR_W-1:0] refr_d [4];
`else
    logic unused_refr;
    assign unused_refr = ^refr_cycles;
`endif

    spike_rr_arb4 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend),
        .advance   (spike_take),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Edge detect, slot-load decision and host-over-spike priority.
    always_comb begin
        prev_d  = spike_in;
        rise    = spike_in & ~prev_q;
        rise_en = rise & {4{en}};
        for (int i = 0; i < 4; i++) pend[i] = (state_q[i] == CH_PENDING);
        load       = en & ~rst & (~upd_valid_q | bus.upd_ready);
        host_take  = load & bus.host_valid;
        spike_take = load & ~bus.host_valid & any_req;
        busy       = (|pend) | upd_valid_q;
    end

    // Per-channel event FSMs and lost-spike detection.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i]  = state_q[i];
            drop_vec[i] = 1'b0;
`ifdef NEURO_SCHED_REFRACTORY_EN
            refr_d[i]   = refr_q[i];
`endif
            case (state_q[i])
                CH_IDLE: begin
                    if (rise_en[i]) state_d[i] = CH_PENDING;
                end
                CH_PENDING: begin
                    if (spike_take && grant[i]) begin
                        if (rise_en[i]) begin
                            state_d[i] = CH_PENDING;
                        end else begin
`ifdef NEURO_SCHED_REFRACTORY_EN
                            if (refr_cycles != '0) begin
                                state_d[i] = CH_REFRACT;
                                refr_d[i]  = refr_cycles;
                            end else begin
                                state_d[i] = CH_IDLE;
                            end
`else
                            state_d[i] = CH_IDLE;
`endif
                        end
                    end else if (rise_en[i]) begin
                        drop_vec[i] = 1'b1;
                    end
                end
`ifdef NEURO_SCHED_REFRACTORY_EN
                CH_REFRACT: begin
                    if (rise_en[i]) drop_vec[i] = 1'b1;
                    if (refr_q[i] <= REFR_W'(1)) begin
                        state_d[i] = CH_IDLE;
                        refr_d[i]  = '0;
                    end else begin
                        refr_d[i]  = refr_q[i] - REFR_W'(1);
                    end
                end
`endif
                default: state_d[i] = CH_IDLE;
            endcase
        end
        n_drop     = 3'(drop_vec[0]) + 3'(drop_vec[1]) + 3'(drop_vec[2]) + 3'(drop_vec[3]);
        drop_sum   = {1'b0, drop_cnt_q} + 9'(n_drop);
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Output slot: hold while stalled, otherwise load host, a granted spike, or empty.
    always_comb begin
        sel_w       = weight_in[grant_idx*W_W +: W_W];
        upd_valid_d = upd_valid_q;
        upd_dir_d   = upd_dir_q;
        upd_mag_d   = upd_mag_q;
        upd_src_d   = upd_src_q;
        if (host_take) begin
            upd_valid_d = 1'b1;
            upd_dir_d   = dir_t'(bus.host_dir);
            upd_mag_d   = bus.host_mag;
            upd_src_d   = 1'b1;
        end else if (spike_take) begin
            upd_valid_d = 1'b1;
            upd_dir_d   = dir_t'(grant_idx);
            upd_mag_d   = MAG_W'(sel_w);
            upd_src_d   = 1'b0;
        end else if (bus.upd_ready) begin
            upd_valid_d = 1'b0;
        end
    end

    // State registers; reset discards pending events without counting them.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= '0;
            upd_valid_q <= 1'b0;
            upd_dir_q   <= DIR_PX;
            upd_mag_q   <= '0;
            upd_src_q   <= 1'b0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= CH_IDLE;
`ifdef NEURO_SCHED_REFRACTORY_EN
                refr_q[i]  <= '0;
`endif
            end
        end else begin
            prev_q      <= prev_d;
            upd_valid_q <= upd_valid_d;
            upd_dir_q   <= upd_dir_d;
            upd_mag_q   <= upd_mag_d;
            upd_src_q   <= upd_src_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
`ifdef NEURO_SCHED_REFRACTORY_EN
                refr_q[i]  <= refr_d[i];
`endif
            end
        end
    end

    assign bus.host_ready = load;
    assign bus.upd_valid  = upd_valid_q;
    assign bus.upd_dir    = upd_dir_q;
    assign bus.upd_mag    = upd_mag_q;
    assign bus.upd_src    = upd_src_q;
    assign drop_cnt       = drop_cnt_q;
endmodule

// File: tb/tb_neuro_spike_scheduler.sv
// Scoreboard bench for neuro_spike_scheduler: expected updates are queued as
// stimulus is driven and checked against every completed update handshake.
module tb_neuro_spike_scheduler;
    localparam int MAG_W  = 16;
    localparam int W_W    = 8;
    localparam int REFR_W = 8;

    typedef struct packed {
        logic [1:0]       dir;
        logic [MAG_W-1:0] mag;
        logic             src;
    } upd_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en;
    logic [3:0]         spike_in;
    logic [4*W_W-1:0]   weight_in;
    logic [REFR_W-1:0]  refr_cycles;
    logic [7:0]         drop_cnt;
    logic               busy;

    upd_t exp_q[$];
    upd_t exp_item, act_item;
    int   n_checks = 0;
    int   n_fail   = 0;

    neuro_spike_scheduler_if #(.MAG_W(MAG_W)) bus ();

    neuro_spike_scheduler #(.MAG_W(MAG_W), .W_W(W_W), .REFR_W(REFR_W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .spike_in    (spike_in),
        .weight_in   (weight_in),
        .refr_cycles (refr_cycles),
        .bus         (bus),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Every accepted update is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.upd_valid && bus.upd_ready) begin
            act_item = '{dir: bus.upd_dir, mag: bus.upd_mag, src: bus.upd_src};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_update: got dir=%0d mag=%h src=%0d, required no update",
                         act_item.dir, act_item.mag, act_item.src);
            end else begin
                exp_item = exp_q.pop_front();
                if (act_item !== exp_item) begin
                    n_fail++;
                    $display("[TB] FAIL update_content: got dir=%0d mag=%h src=%0d, required dir=%0d mag=%h src=%0d",
                             act_item.dir, act_item.mag, act_item.src, exp_item.dir, exp_item.mag, exp_item.src);
                end
            end
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] dir, input logic [MAG_W-1:0] mag, input logic src);
        exp_q.push_back('{dir: dir, mag: mag, src: src});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int c = 0;
        while ((exp_q.size() != 0 || bus.upd_valid) && c < budget) begin
            tick();
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.upd_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_drain: got %0d outstanding valid=%b, required 0 outstanding valid=0",
                     name, exp_q.size(), bus.upd_valid);
        end
    endtask

    task automatic test_reset();
        en = 1'b0; spike_in = 4'h0; refr_cycles = '0;
        weight_in = {8'd9, 8'd7, 8'd5, 8'd3};
        bus.host_valid = 1'b0; bus.host_dir = 2'd0; bus.host_mag = '0; bus.upd_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.upd_valid, bus.upd_dir, bus.upd_mag, bus.upd_src, drop_cnt, busy, bus.host_ready} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got valid=%b dir=%0d mag=%h src=%b drop=%h busy=%b hrdy=%b, required all 0",
                     bus.upd_valid, bus.upd_dir, bus.upd_mag, bus.upd_src, drop_cnt, busy, bus.host_ready);
        end
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_single_spike();
        en = 1'b1; bus.upd_ready = 1'b1;
        spike_in = 4'b0001;
        push(2'd0, 16'd3, 1'b0);
        tick();
        n_checks++;
        if (bus.upd_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_lat1: got valid=%b, required 0", bus.upd_valid);
        end
        tick();
        n_checks++;
        if (bus.upd_valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL single_lat2: got valid=%b, required 1", bus.upd_valid);
        end
        spike_in = 4'b0000;
        tick();
        n_checks++;
        if (bus.upd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_once: got valid=%b busy=%b, required 0 0", bus.upd_valid, busy);
        end
        wait_drain(10, "single");
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 1'b1; bus.upd_ready = 1'b1;
        for (int burst = 0; burst < 2; burst++) begin
            spike_in = 4'hF;
            push(2'd0, 16'd3, 1'b0); push(2'd1, 16'd5, 1'b0);
            push(2'd2, 16'd7, 1'b0); push(2'd3, 16'd9, 1'b0);
            tick();
            spike_in = 4'h0;
            for (int k = 0; k < 4; k++) begin
                tick();
                n_checks++;
                if (bus.upd_valid !== 1'b1 || bus.upd_dir !== 2'(k)) begin
                    n_fail++;
                    $display("[TB] FAIL rr_order: got valid=%b dir=%0d, required valid=1 dir=%0d",
                             bus.upd_valid, bus.upd_dir, k);
                end
            end
            tick();
            n_checks++;
            if (bus.upd_valid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL rr_end: got valid=%b, required 0", bus.upd_valid);
            end
        end
        wait_drain(10, "rr");
    endtask

    task automatic test_host_priority();
        spike_in = 4'b0001;
        push(2'd3, 16'h0100, 1'b1);
        push(2'd0, 16'd3, 1'b0);
        tick();
        spike_in = 4'b0000;
        bus.host_valid = 1'b1; bus.host_dir = 2'd3; bus.host_mag = 16'h0100;
        n_checks++;
        if (bus.host_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL host_ready: got %b, required 1", bus.host_ready);
        end
        tick();
        bus.host_valid = 1'b0;
        n_checks++;
        if (bus.upd_valid !== 1'b1 || bus.upd_src !== 1'b1) begin
            n_fail++; $display("[TB] FAIL host_first: got valid=%b src=%b, required 1 1", bus.upd_valid, bus.upd_src);
        end
        tick();
        n_checks++;
        if (bus.upd_valid !== 1'b1 || bus.upd_src !== 1'b0 || bus.upd_dir !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL host_then_e: got valid=%b src=%b dir=%0d, required 1 0 0",
                     bus.upd_valid, bus.upd_src, bus.upd_dir);
        end
        wait_drain(10, "host");
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        do_reset();
        en = 1'b1; bus.upd_ready = 1'b0;
        bus.host_valid = 1'b1; bus.host_dir = 2'd1; bus.host_mag = 16'h0042;
        push(2'd1, 16'h0042, 1'b1);
        tick();
        bus.host_valid = 1'b0;
        n_checks++;
        if (bus.host_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_host_ready: got %b, required 0", bus.host_ready);
        end
        for (int k = 0; k < 5; k++) begin
            spike_in = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            if (bus.upd_valid !== 1'b1 || bus.upd_dir !== 2'd1 || bus.upd_mag !== 16'h0042 || bus.upd_src !== 1'b1)
                unstable++;
        end
        spike_in = 4'b0000;
        n_checks++;
        if (unstable != 0) begin
            n_fail++; $display("[TB] FAIL bp_stable: got %0d unstable cycles, required 0", unstable);
        end
        n_checks++;
        if (drop_cnt !== 8'd2 || busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_drops: got drop=%0d busy=%b, required 2 1", drop_cnt, busy);
        end
        push(2'd1, 16'd5, 1'b0);
        bus.upd_ready = 1'b1;
        wait_drain(10, "bp");
    endtask

    task automatic test_drop_saturate();
        do_reset();
        en = 1'b1; bus.upd_ready = 1'b0;
        bus.host_valid = 1'b1; bus.host_dir = 2'd2; bus.host_mag = 16'h1234;
        push(2'd2, 16'h1234, 1'b1);
        tick();
        bus.host_valid = 1'b0;
        spike_in = 4'b0010; tick(); spike_in = 4'b0000; tick();
        for (int n = 1; n <= 300; n++) begin
            spike_in = 4'b0010; tick(); spike_in = 4'b0000; tick();
            if (n == 254 || n == 255 || n == 300) begin
                n_checks++;
                if (drop_cnt !== ((n == 254) ? 8'hFE : 8'hFF)) begin
                    n_fail++;
                    $display("[TB] FAIL sat_%0d: got drop=%h, required %h", n, drop_cnt, (n == 254) ? 8'hFE : 8'hFF);
                end
            end
        end
        push(2'd1, 16'd5, 1'b0);
        bus.upd_ready = 1'b1;
        wait_drain(10, "sat");
    endtask

    task automatic test_enable();
        en = 1'b1; bus.upd_ready = 1'b0;
        bus.host_valid = 1'b1; bus.host_dir = 2'd2; bus.host_mag = 16'd7;
        push(2'd2, 16'd7, 1'b1);
        tick();
        en = 1'b0; bus.upd_ready = 1'b1;
        spike_in = 4'b0001;
        n_checks++;
        if (bus.host_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL en0_host_ready: got %b, required 0", bus.host_ready);
        end
        tick();
        spike_in = 4'b0000;
        tick();
        tick();
        bus.host_valid = 1'b0;
        n_checks++;
        if (bus.upd_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL en0_ignore: got valid=%b busy=%b outstanding=%0d, required 0 0 0",
                     bus.upd_valid, busy, exp_q.size());
        end
        en = 1'b1;
    endtask

`ifdef NEURO_SCHED_REFRACTORY_EN
    task automatic test_refractory();
        do_reset();
        en = 1'b1; bus.upd_ready = 1'b1; refr_cycles = 8'd4;
        spike_in = 4'b0001;
        push(2'd0, 16'd3, 1'b0);
        tick();
        spike_in = 4'b0000;
        tick();
        tick();
        spike_in = 4'b0001;
        tick();
        n_checks++;
        if (drop_cnt !== 8'd1) begin
            n_fail++; $display("[TB] FAIL refr_drop: got drop=%0d, required 1", drop_cnt);
        end
        spike_in = 4'b0000;
        tick();
        tick();
        spike_in = 4'b0001;
        push(2'd0, 16'd3, 1'b0);
        tick();
        spike_in = 4'b0000;
        wait_drain(10, "refr");
        n_checks++;
        if (drop_cnt !== 8'd1) begin
            n_fail++; $display("[TB] FAIL refr_after: got drop=%0d, required 1", drop_cnt);
        end
        refr_cycles = '0;
    endtask
`endif

    task automatic test_reset_midflight();
        en = 1'b1; bus.upd_ready = 1'b0;
        bus.host_valid = 1'b1; bus.host_dir = 2'd3; bus.host_mag = 16'hBEEF;
        push(2'd3, 16'hBEEF, 1'b1);
        tick();
        bus.host_valid = 1'b0;
        spike_in = 4'b0010; tick(); spike_in = 4'b0000; tick();
        n_checks++;
        if (bus.upd_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL mid_pre: got valid=%b busy=%b, required 1 1", bus.upd_valid, busy);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus.upd_valid, bus.upd_dir, bus.upd_mag, bus.upd_src, drop_cnt, busy, bus.host_ready} !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got valid=%b dir=%0d mag=%h src=%b drop=%h busy=%b hrdy=%b, required all 0",
                     bus.upd_valid, bus.upd_dir, bus.upd_mag, bus.upd_src, drop_cnt, busy, bus.host_ready);
        end
        exp_q.delete();
        rst = 1'b0;
        bus.upd_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (bus.upd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_after: got valid=%b busy=%b, required 0 0", bus.upd_valid, busy);
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single_spike();
        test_round_robin();
        test_host_priority();
        test_backpressure();
        test_drop_saturate();
        test_enable();
`ifdef NEURO_SCHED_REFRACTORY_EN
        test_refractory();
`endif
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
